// File: rtl/step_capture_bank.sv
// rtl/step_capture_bank.sv - banked step-qualified capture with live forwarding and cycle step counter
module step_capture_bank #(
   parameter int WIDTH     = 16,
   parameter int CHANNELS  = 4,
   parameter int STEPS     = 4,
   parameter int STEP_BITS = 2
) (
   input  logic                          clock,
   input  logic                          async_reset_n,
   input  logic                          advance,
   input  logic                          restart,
   input  logic [CHANNELS*STEP_BITS-1:0] capture_on,
   input  logic [CHANNELS-1:0]           hold,
   input  logic [CHANNELS*WIDTH-1:0]     input_value,
   output logic [STEP_BITS-1:0]          current_step,
   output logic [CHANNELS*WIDTH-1:0]     captured_out,
   output logic [CHANNELS-1:0]           captured_valid,
   output logic                          cycle_done
);

   localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'(STEPS - 1);

   logic [STEP_BITS-1:0] step_q;
   logic [STEP_BITS-1:0] step_d;
   logic                 wrap;
   logic                 to_zero;
   logic                 done_q;

   always_comb begin
      wrap    = advance && !restart && (step_q == LAST_STEP);
      to_zero = restart || wrap;
      step_d  = step_q;
      if (to_zero) begin
         step_d = '0;
      end else if (advance) begin
         step_d = step_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge async_reset_n) begin
      if (!async_reset_n) begin
         step_q <= '0;
         done_q <= 1'b0;
      end else begin
         step_q <= step_d;
         done_q <= wrap;
      end
   end

   assign current_step = step_q;
   assign cycle_done   = done_q;

   // A capture_on value >= STEPS can never equal the counter, so such a channel simply never matches.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic             match;
      logic             capture;
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      assign match   = (step_q == capture_on[c*STEP_BITS +: STEP_BITS]) && !hold[c];
      assign capture = match && advance && !restart;

      always_ff @(posedge clock or negedge async_reset_n) begin
         if (!async_reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            if (capture) begin
               data_q <= input_value[c*WIDTH +: WIDTH];
            end
            // Capture on the wrap edge outranks the clear that wrap would otherwise cause.
            if (capture) begin
               valid_q <= 1'b1;
            end else if (to_zero) begin
               valid_q <= 1'b0;
            end
         end
      end

      assign captured_out[c*WIDTH +: WIDTH] = match ? input_value[c*WIDTH +: WIDTH] : data_q;
      assign captured_valid[c]              = valid_q;
   end

endmodule

// File: tb/tb_step_capture_bank.sv
// tb/tb_step_capture_bank.sv - scoreboard bench for step_capture_bank (STEPS=4 and STEPS=3 instances)
module tb_step_capture_bank;

   localparam int W  = 16;
   localparam int CH = 4;
   localparam int SB = 2;

   logic              clock;
   logic              async_reset_n;
   logic              advance;
   logic              restart;
   logic [CH*SB-1:0]  capture_on;
   logic [CH-1:0]     hold;
   logic [CH*W-1:0]   input_value;
   logic [W-1:0]      in_val [CH];

   logic [SB-1:0]     step4, step3;
   logic [CH*W-1:0]   out4, out3;
   logic [CH-1:0]     valid4, valid3;
   logic              done4, done3;

   int n_checks;
   int n_errors;

   typedef struct {
      string      tag;
      int         kind;
      int         ch;
      logic [W-1:0] val;
   } exp_t;

   exp_t sb_q[$];

   always_comb begin
      input_value = '0;
      for (int i = 0; i < CH; i++) input_value[i*W +: W] = in_val[i];
   end

   step_capture_bank #(.WIDTH(W), .CHANNELS(CH), .STEPS(4), .STEP_BITS(SB)) u_dut (
      .clock(clock), .async_reset_n(async_reset_n), .advance(advance), .restart(restart),
      .capture_on(capture_on), .hold(hold), .input_value(input_value),
      .current_step(step4), .captured_out(out4), .captured_valid(valid4), .cycle_done(done4)
   );

   step_capture_bank #(.WIDTH(W), .CHANNELS(CH), .STEPS(3), .STEP_BITS(SB)) u_dut3 (
      .clock(clock), .async_reset_n(async_reset_n), .advance(advance), .restart(restart),
      .capture_on(capture_on), .hold(hold), .input_value(input_value),
      .current_step(step3), .captured_out(out3), .captured_valid(valid3), .cycle_done(done3)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // kinds: 0 out ch, 1 valid ch, 2 step, 3 cycle_done, 4 STEPS=3 out ch, 5 STEPS=3 valid ch, 6 valid vector
   task automatic expect_val(input string tag, input int kind, input int ch, input logic [W-1:0] val);
      exp_t e;
      e.tag = tag; e.kind = kind; e.ch = ch; e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic expect_oor();
      expect_val("oor_out", 4, 2, 16'h0000);
      expect_val("oor_valid", 5, 2, 16'h0000);
   endtask

   task automatic drain();
      exp_t e;
      logic [W-1:0] got;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.kind)
            0:       got = out4[e.ch*W +: W];
            1:       got = W'(valid4[e.ch]);
            2:       got = W'(step4);
            3:       got = W'(done4);
            4:       got = out3[e.ch*W +: W];
            5:       got = W'(valid3[e.ch]);
            default: got = W'(valid4);
         endcase
         check_eq(e.tag, got, e.val);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      async_reset_n = 1'b0;
      advance = 1'b0;
      restart = 1'b0;
      hold = '0;
      capture_on = {2'd3, 2'd3, 2'd2, 2'd1};
      in_val[0] = 16'h1234; in_val[1] = 16'hBEEF; in_val[2] = 16'h7777; in_val[3] = 16'h5555;
      #2;
      expect_val("rst_step", 2, 0, 0);
      expect_val("rst_out0", 0, 0, 0);
      expect_val("rst_valid", 6, 0, 0);
      expect_val("rst_done", 3, 0, 0);
      drain();

      cycle();
      async_reset_n = 1'b1;
      advance = 1'b1;
      cycle();
      in_val[0] = 16'hA5A5;
      #1;
      expect_val("basic_step1", 2, 0, 1);
      expect_val("basic_fwd", 0, 0, 16'hA5A5);
      expect_val("basic_valid_s1", 1, 0, 0);
      expect_oor();
      drain();

      cycle();
      in_val[0] = 16'h1234;
      #1;
      expect_val("basic_held_s2", 0, 0, 16'hA5A5);
      expect_val("basic_valid_s2", 1, 0, 1);
      expect_val("basic_ch1_fwd", 0, 1, 16'hBEEF);
      expect_val("basic_nodone", 3, 0, 0);
      drain();

      cycle();
      #1;
      expect_val("basic_held_s3", 0, 0, 16'hA5A5);
      expect_val("basic_ch3_fwd", 0, 3, 16'h5555);
      expect_oor();
      drain();

      cycle();
      #1;
      expect_val("wrap_step", 2, 0, 0);
      expect_val("wrap_done", 3, 0, 1);
      expect_val("wrap_ch3", 0, 3, 16'h5555);
      expect_val("wrap_valid3", 1, 3, 1);
      expect_val("wrap_valid0_clr", 1, 0, 0);
      drain();

      cycle();
      advance = 1'b0;
      in_val[0] = 16'h0001;
      #1;
      expect_val("done_pulse_end", 3, 0, 0);
      expect_val("stall_fwd1", 0, 0, 16'h0001);
      drain();
      for (int i = 2; i <= 3; i++) begin
         cycle();
         in_val[0] = W'(i);
         #1;
         expect_val("stall_step", 2, 0, 1);
         expect_val("stall_fwd", 0, 0, W'(i));
         expect_val("stall_valid", 1, 0, 0);
         drain();
      end
      cycle();
      advance = 1'b1;
      in_val[0] = 16'h0004;
      hold[1] = 1'b1;
      in_val[1] = 16'h1111;
      #1;
      expect_val("stall_fwd4", 0, 0, 16'h0004);
      drain();

      cycle();
      #1;
      expect_val("stall_cap", 0, 0, 16'h0004);
      expect_val("stall_valid_set", 1, 0, 1);
      expect_val("hold_no_fwd", 0, 1, 16'hBEEF);
      expect_oor();
      drain();

      cycle();
      hold[1] = 1'b0;
      #1;
      expect_val("hold_no_cap", 0, 1, 16'hBEEF);
      expect_val("hold_valid", 1, 1, 0);
      drain();

      cycle();
      cycle();
      in_val[0] = 16'h9999;
      restart = 1'b1;
      #1;
      expect_val("pre_rst_step", 2, 0, 1);
      expect_val("pre_rst_valid3", 1, 3, 1);
      drain();

      cycle();
      restart = 1'b0;
      #1;
      expect_val("restart_step", 2, 0, 0);
      expect_val("restart_reg0", 0, 0, 16'h0004);
      expect_val("restart_valid", 6, 0, 0);
      expect_val("restart_nodone", 3, 0, 0);
      drain();

      cycle();
      cycle();
      #1;
      expect_val("reload_ch0", 0, 0, 16'h9999);
      drain();
      async_reset_n = 1'b0;
      #1;
      expect_val("async_step", 2, 0, 0);
      expect_val("async_out0", 0, 0, 0);
      expect_val("async_out3", 0, 3, 0);
      expect_val("async_valid", 6, 0, 0);
      expect_val("async_done", 3, 0, 0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/step_capture_bank.md
Name: step_capture_bank

Overview:
- Multi-channel, parametrised capture unit with an integrated step sequencer.
- Owns the processor step counter (0..STEPS-1).
- Each channel latches its input value at the end of a programmable step.
- Each channel forwards the live input during its capture step and presents the held value for the rest of the instruction cycle.
- Replaces per-signal capture instances in the decode/execute datapath with one banked block, and adds per-channel hold, captured-valid flags and a cycle-done pulse.

Parameters:
- WIDTH, 16, bits per channel value.
- CHANNELS, 4, number of independent capture channels.
- STEPS, 4, steps per instruction cycle (2..2^STEP_BITS).
- STEP_BITS, 2, width of the step counter and of each capture_on field.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- async_reset_n  input  1  asynchronous, active-low reset.
- advance  input  1  step counter increments on this edge; also qualifies capture.
- restart  input  1  synchronous, forces the step counter to 0; priority over advance.
- capture_on  input  CHANNELS*STEP_BITS  per-channel capture step; channel c = bits [c*STEP_BITS +: STEP_BITS].
- hold  input  CHANNELS  per-channel capture suppress; held channel keeps its old value and does not forward.
- input_value  input  CHANNELS*WIDTH  per-channel live value; channel c = bits [c*WIDTH +: WIDTH].
- current_step  output  STEP_BITS  registered step counter.
- captured_out  output  CHANNELS*WIDTH  per-channel forwarded or held value.
- captured_valid  output  CHANNELS  per-channel flag: value captured in the current cycle.
- cycle_done  output  1  one-clock registered pulse after the step counter wraps to 0.

Behaviour:
- Reset (async_reset_n=0, asynchronous, any time including mid-cycle):
  - current_step=0, all capture registers=0, captured_valid=0, cycle_done=0.
  - Release is synchronous to the next rising edge.
- Step counter, evaluated per edge:
  - restart=1: step<=0.
  - Else advance=1: step<=(step==STEPS-1) ? 0 : step+1.
  - Else: hold the step.
  - Never takes values >= STEPS.
- cycle_done:
  - Registered; equals 1 for exactly one clock after an edge where advance=1, restart=0 and step==STEPS-1.
  - restart never asserts cycle_done.
- Channel match: match[c] = (current_step == capture_on[c]) && !hold[c].
  - capture_on[c] >= STEPS never matches.
  - Such a channel never captures and always outputs its register.
- Capture: on an edge with match[c]=1, advance=1 and restart=0, reg[c]<=input_value[c].
  - Capture occurs at the edge that leaves the capture step.
  - Stalled cycles (advance=0) do not capture; the output keeps forwarding.
- Forwarding (combinational): captured_out[c] = match[c] ? input_value[c] : reg[c].
  - Zero-latency bypass during the capture step.
  - Seamless hand-over to the held value on the following step.
- captured_valid[c]:
  - Set by a capture.
  - Cleared on any edge where the step counter moves to 0 (wrap or restart).
  - If capture and wrap occur on the same edge (capture_on[c]==STEPS-1), the capture wins and valid<=1.
- restart and capture on the same edge: restart wins. No register update; valid cleared.
- hold[c]=1 blocks capture and forwarding only. It does not clear reg[c] or captured_valid[c].
- Channels are fully independent. Any subset may share a capture step.
- No width conversion; values pass bit-exact.

Test Plan:
- Reset/idle: assert async_reset_n=0 mid-step 2 with regs loaded.
  -> current_step=0, captured_out=0, captured_valid=0 immediately, without a clock edge.
- Basic capture: WIDTH=16, ch0 capture_on=1, advance=1 continuously, input 0xA5A5 during step 1, 0x1234 afterward.
  -> captured_out ch0 = 0xA5A5 during step 1 (forwarded) and steps 2,3; valid ch0 rises entering step 2; cycle_done pulses once after step 3->0.
- Stall: advance=0 for 3 clocks in step 1 with input changing 0x0001->0x0002->0x0003, then advance=1 with 0x0004.
  -> output tracks input while stalled; the register captures 0x0004.
- Hold and out-of-range: ch1 hold=1 across its step; ch2 capture_on=3 with STEPS=3.
  -> ch1 keeps its previous value (0xBEEF) and valid state; ch2 never changes from 0.
- Wrap-edge capture: ch3 capture_on=STEPS-1, input 0x5555.
  -> after the wrap edge, ch3 = 0x5555, valid=1, current_step=0, cycle_done=1.
- Restart priority: restart=1 and advance=1 on the capture edge of ch0 (step 1).
  -> step=0, ch0 register unchanged, all valid=0, cycle_done=0.
